ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It runs beside the existing PS/2 keyboard receiver, which only listens, and drives the same open-drain `ps2_clk` and `ps2_data` lines. It performs the host request-to-send sequence, serialises a 10-bit frame (8 data bits, odd parity, stop) on device-generated clocks, and checks the device acknowledge.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_line_sync.sv | 43 ++++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks.
//   state_t        host transmitter state encoding
//   *_DEF          default cycle counts at a 50 MHz system clock
//   odd_parity()   parity bit that makes the 9-bit {parity, data} word odd
//   cnt_width()    width of a down-to-zero cycle counter covering all limits
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_RELEASE
   } state_t;

   localparam int unsigned INHIBIT_CYCLES_DEF = 5000;    // 100 us
   localparam int unsigned RTS_CYCLES_DEF     = 100;     // 2 us
   localparam int unsigned TIMEOUT_CYCLES_DEF = 750000;  // 15 ms

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned FRAME_BITS = 10;              // data, parity, stop
   localparam logic [3:0]  LAST_DATA_EDGE = 4'd9;        // count value before edge 10
   localparam logic [3:0]  BIT_CNT_MAX    = 4'd11;

   function automatic logic odd_parity(input logic [BYTE_W-1:0] d);
      return ~^d;
   endfunction

   // Wide enough to hold (largest limit - 1).
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_if
// Command handshake between a requester and the PS/2 host transmitter.
//   tx_data   byte to send, sampled on the tx_start cycle
//   tx_start  one-cycle send request
//   tx_busy   transfer in progress
//   tx_done   one-cycle pulse: device acknowledged
//   tx_error  one-cycle pulse: NACK or watchdog expiry
// master = requester, slave = transmitter.
// -----------------------------------------------------------------------------
interface ps2_host_tx_if;
   import ps2_pkg::*;

   logic [BYTE_W-1:0] tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_error;

   modport master (
      output tx_data, tx_start,
      input  tx_busy, tx_done, tx_error
   );

   modport slave (
      input  tx_data, tx_start,
      output tx_busy, tx_done, tx_error
   );

endinterface

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings the asynchronous PS/2 clock and data lines into the system clock
// domain and flags falling edges of the clock line. Shared with the receiver.
//   clk       system clock
//   rst_n     asynchronous active-low reset (flops preset to the idle-high level)
//   clk_in    raw PS/2 clock line
//   data_in   raw PS/2 data line
//   clk_s     synchronised clock line
//   data_s    synchronised data line
//   clk_fall  one-cycle pulse when clk_s goes 1 -> 0
// -----------------------------------------------------------------------------
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], clk_in};
         data_ff  <= {data_ff[0], data_in};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_s    = clk_ff[1];
   assign data_s   = data_ff[1];
   assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Performs the request-to-send
// sequence, shifts out {stop, odd parity, data LSB first} on device-generated
// clocks and checks the device acknowledge on the 11th falling edge.
//   clk_50mhz  system clock
//   rst_n      asynchronous active-low reset; releases both lines at once
//   ps2_clk    open-drain PS/2 clock (driven 0 or z)
//   ps2_data   open-drain PS/2 data  (driven 0 or z)
//   bus        ps2_host_tx_if.slave: tx_data, tx_start, tx_busy, tx_done, tx_error
// Optional feature: define PS2_TX_TIMEOUT_EN to add a watchdog that aborts with
// tx_error when no falling clock edge arrives for TIMEOUT_CYCLES after the
// clock is released. Without it a silent device stalls the block in SEND.
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int unsigned RTS_CYCLES     = RTS_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         clk_50mhz,
   input  logic         rst_n,
   inout  wire          ps2_clk,
   inout  wire          ps2_data,
   ps2_host_tx_if.slave bus
);

   // One counter serves the inhibit and RTS phases and, when enabled, the
   // watchdog; its width covers the largest of the three limits.
   localparam int unsigned CNT_W = cnt_width(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cyc_cnt;
   logic [3:0]            bit_cnt;
   logic [FRAME_BITS-1:0] frame;
   logic                  data_low_q;
   logic                  done_q;
   logic                  error_q;
   logic                  fin_done;
   logic                  fin_err;

   logic                  clk_s;
   logic                  data_s;
   logic                  clk_fall;
   logic                  clk_low;
   logic                  data_low;

   logic                  inhibit_end;
   logic                  rts_end;
   logic                  wd_expired;

   ps2_line_sync u_sync (
      .clk      (clk_50mhz),
      .rst_n    (rst_n),
      .clk_in   (ps2_clk),
      .data_in  (ps2_data),
      .clk_s    (clk_s),
      .data_s   (data_s),
      .clk_fall (clk_fall)
   );

   assign inhibit_end = (cyc_cnt == CNT_W'(INHIBIT_CYCLES - 1));
   assign rts_end     = (cyc_cnt == CNT_W'(RTS_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
   // Counter restarts at 0 on entry to SEND, so the error pulse lands exactly
   // TIMEOUT_CYCLES after the clock is released (or after the last edge).
   assign wd_expired = (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign wd_expired = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      fin_done  = 1'b0;
      fin_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.tx_start) state_nxt = ST_INHIBIT;
         end
         ST_INHIBIT: begin
            if (inhibit_end) state_nxt = ST_RTS;
         end
         ST_RTS: begin
            if (rts_end) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (clk_fall) begin
               if (bit_cnt == LAST_DATA_EDGE) state_nxt = ST_ACK;
            end else if (wd_expired) begin
               state_nxt = ST_IDLE;
               fin_err   = 1'b1;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               if (data_s) begin
                  state_nxt = ST_IDLE;
                  fin_err   = 1'b1;
               end else begin
                  state_nxt = ST_RELEASE;
               end
            end else if (wd_expired) begin
               state_nxt = ST_IDLE;
               fin_err   = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (clk_s && data_s) begin
               state_nxt = ST_IDLE;
               fin_done  = 1'b1;
            end else if (wd_expired) begin
               state_nxt = ST_IDLE;
               fin_err   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: the clock is held low only while inhibiting / requesting;
   // the data drive comes from a register so it only moves on clock edges.
   always_comb begin
      clk_low     = (state == ST_INHIBIT) || (state == ST_RTS);
      data_low    = data_low_q;
      bus.tx_busy = (state != ST_IDLE);
   end

   assign bus.tx_done  = done_q;
   assign bus.tx_error = error_q;

   assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = data_low ? 1'b0 : 1'bz;

   // Control registers
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         data_low_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         done_q  <= fin_done;
         error_q <= fin_err;

         if (state_nxt != state) begin
            cyc_cnt <= '0;
         end else begin
            case (state)
               ST_INHIBIT, ST_RTS: cyc_cnt <= cyc_cnt + CNT_W'(1);
`ifdef PS2_TX_TIMEOUT_EN
               ST_SEND, ST_ACK, ST_RELEASE:
                  cyc_cnt <= clk_fall ? '0 : cyc_cnt + CNT_W'(1);
`endif
               default: cyc_cnt <= '0;
            endcase
         end

         if (state == ST_IDLE && bus.tx_start) begin
            bit_cnt <= '0;
         end else if ((state == ST_SEND || state == ST_ACK) && clk_fall &&
                      bit_cnt != BIT_CNT_MAX) begin
            bit_cnt <= bit_cnt + 4'd1;
         end

         // Every exit to IDLE (done, NACK, timeout) frees the data line in
         // the same cycle as the pulse. The start bit goes out with RTS and
         // stays until the first device edge replaces it with data bit 0.
         if (state_nxt == ST_IDLE) begin
            data_low_q <= 1'b0;
         end else if (state == ST_INHIBIT && inhibit_end) begin
            data_low_q <= 1'b1;
         end else if (state == ST_SEND && clk_fall) begin
            data_low_q <= ~frame[0];
         end
      end
   end

   // Frame shift register (datapath, no reset needed)
   always_ff @(posedge clk_50mhz) begin
      if (state == ST_IDLE && bus.tx_start) begin
         frame <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
      end else if (state == ST_SEND && clk_fall) begin
         frame <= {1'b1, frame[FRAME_BITS-1:1]};
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INH = 40;
   localparam int unsigned RTS = 8;
   localparam int unsigned TO  = 300;
   localparam int          H   = 15;     // device clock half period in cycles
   localparam int          BOUND = 3000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   wire  ps2_clk;
   wire  ps2_data;
   pullup (ps2_clk);
   pullup (ps2_data);

   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

   ps2_host_tx_if bus ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_50mhz (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [9:0] frame;
      bit         is_err;
      bit         chk_frame;
      bit         chk_to;
   } exp_t;
   exp_t exp_q[$];

   // device model state
   int         dev_mode = 0;    // 0 ack, 1 nack, 2 silent
   bit         dev_busy = 1'b0;
   logic [9:0] dev_bits = '0;
   logic       dev_start = 1'b1;
   int         dev_inh = 0;
   int         dev_rts = 0;
   int         dev_edges = 0;
   int         dev_rel_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [9:0] f, input bit e, input bit cf, input bit ct);
      exp_t x;
      x.frame = f; x.is_err = e; x.chk_frame = cf; x.chk_to = ct;
      exp_q.push_back(x);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.tx_data  = b;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || dev_busy) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no response after %0d cycles, %0d expected still pending", name, n, exp_q.size());
         exp_q.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   // PS/2 device model: watches the host request, then clocks the frame in
   initial begin
      forever begin
         @(negedge clk);
         if (ps2_clk === 1'b0 && !dev_clk_low) begin
            dev_busy  = 1'b1;
            dev_inh   = 0;
            dev_rts   = 0;
            dev_edges = 0;
            dev_bits  = '0;
            while (ps2_clk === 1'b0) begin
               dev_inh++;
               if (ps2_data === 1'b0) dev_rts++;
               @(negedge clk);
            end
            dev_rel_cyc = cyc;
            dev_start   = ps2_data;
            if (dev_mode != 2) begin
               repeat (10) @(negedge clk);
               for (int k = 1; k <= 11; k++) begin
                  if (k == 11 && dev_mode == 0) begin
                     dev_data_low = 1'b1;
                     repeat (3) @(negedge clk);
                  end
                  dev_clk_low = 1'b1;
                  repeat (H) @(negedge clk);
                  if (k <= 10) dev_bits[k-1] = ps2_data;
                  dev_edges   = k;
                  dev_clk_low = 1'b0;
                  repeat (H) @(negedge clk);
               end
               dev_data_low = 1'b0;
            end
            dev_busy = 1'b0;
         end
      end
   end

   // Monitor: pops one expectation per done/error pulse
   logic busy_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.tx_done === 1'b1 || bus.tx_error === 1'b1) begin
            check("pulse_exclusive", 32'(bus.tx_done & bus.tx_error), 32'(0));
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_pulse: done=%0b error=%0b, required no pulse", bus.tx_done, bus.tx_error);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind_error", 32'(bus.tx_error), 32'(e.is_err));
               check("busy_falls_with_pulse", 32'({busy_prev, bus.tx_busy}), 32'(2'b10));
               check("clk_released", 32'(ps2_clk), 32'(!dev_clk_low));
               check("data_released", 32'(ps2_data), 32'(!dev_data_low));
               check("clk_low_len", 32'(dev_inh), 32'(INH + RTS));
               check("rts_data_low_len", 32'(dev_rts), 32'(RTS));
               check("start_bit", 32'(dev_start), 32'(0));
               if (e.chk_frame) check("frame_bits", 32'(dev_bits), 32'(e.frame));
               if (e.chk_to)    check("timeout_len", 32'(cyc - dev_rel_cyc), 32'(TO));
            end
         end
         busy_prev = bus.tx_busy;
      end
   end

   initial begin
      int n;
      bus.tx_data  = 8'h00;
      bus.tx_start = 1'b0;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_busy",  32'(bus.tx_busy),  32'(0));
      check("rst_done",  32'(bus.tx_done),  32'(0));
      check("rst_error", 32'(bus.tx_error), 32'(0));
      check("rst_clk_z", 32'(ps2_clk),      32'(1));
      check("rst_data_z", 32'(ps2_data),    32'(1));
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
      push(10'h3ED, 1'b0, 1'b1, 1'b0);
      send(8'hED);
      check("busy_after_start", 32'(bus.tx_busy), 32'(1));
      wait_drain("frame_ed");

      // 0x07: parity 0
      push(10'h207, 1'b0, 1'b1, 1'b0);
      send(8'h07);
      wait_drain("frame_07");

      // 0x00: parity 1
      push(10'h300, 1'b0, 1'b1, 1'b0);
      send(8'h00);
      wait_drain("frame_00");

      // NACK on 0x3C (parity 1)
      dev_mode = 1;
      push(10'h33C, 1'b1, 1'b1, 1'b0);
      send(8'h3C);
      wait_drain("frame_nack");
      check("nack_idle_busy", 32'(bus.tx_busy), 32'(0));
      check("nack_lines_z", 32'({ps2_clk, ps2_data}), 32'(2'b11));
      dev_mode = 0;

      // 0xF4 with a 0xFF request in mid-frame (parity 0)
      push(10'h2F4, 1'b0, 1'b1, 1'b0);
      send(8'hF4);
      n = 0;
      while (!(dev_busy && dev_edges >= 3) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) begin
         n_cmp++; n_fail++;
         $display("FAIL f4_edge3_wait: waited %0d cycles, required edge 3", n);
      end
      send(8'hFF);
      wait_drain("frame_f4");

      // reset after edge 5 of 0xA5 (bit 4 is 0, so data is driven low)
      send(8'hA5);
      n = 0;
      while (!(dev_busy && dev_edges >= 5 && !dev_clk_low) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) begin
         n_cmp++; n_fail++;
         $display("FAIL a5_edge5_wait: waited %0d cycles, required edge 5", n);
      end
      repeat (4) @(negedge clk);
      check("pre_reset_data_low", 32'(ps2_data), 32'(0));
      rst_n = 1'b0;
      #1;
      check("reset_clk_z",  32'(ps2_clk),      32'(1));
      check("reset_data_z", 32'(ps2_data),     32'(1));
      check("reset_busy",   32'(bus.tx_busy),  32'(0));
      check("reset_error",  32'(bus.tx_error), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      wait_drain("abort_settle");

      push(10'h3A5, 1'b0, 1'b1, 1'b0);
      send(8'hA5);
      wait_drain("frame_a5_after_reset");

`ifdef PS2_TX_TIMEOUT_EN
      dev_mode = 2;
      push(10'h000, 1'b1, 1'b0, 1'b1);
      send(8'h55);
      wait_drain("timeout");
      dev_mode = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
